// File: rtl/shift_feeder.sv
// Parallel-to-serial feeder for the downstream shift-register stage.
// Ports: clk/rst, in_valid/in_ready/in_data/in_dir handshake, ser_dout/ser_sel serial drive, busy, word_done.
module shift_feeder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             ser_dout,
  output logic [1:0]       ser_sel,
  output logic             busy,
  output logic             word_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_CLR   = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic             dir;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      dir       <= 1'b0;
      cnt       <= '0;
      ser_dout  <= 1'b0;
      ser_sel   <= SEL_CLR;
      busy      <= 1'b0;
      word_done <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      word_done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            // First bit goes out immediately; shadow keeps the rest.
            state    <= SHIFT;
            dir      <= in_dir;
            cnt      <= CNT_W'(WIDTH - 1);
            busy     <= 1'b1;
            in_ready <= 1'b0;
            if (in_dir) begin
              ser_dout <= in_data[0];
              shadow   <= in_data >> 1;
              ser_sel  <= SEL_RIGHT;
            end else begin
              ser_dout <= in_data[WIDTH-1];
              shadow   <= in_data << 1;
              ser_sel  <= SEL_LEFT;
            end
          end else begin
            state    <= IDLE;
            ser_dout <= 1'b0;
            ser_sel  <= SEL_CLR;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            state     <= DONE;
            word_done <= 1'b1;
            busy      <= 1'b0;
            ser_sel   <= SEL_CLR;
            ser_dout  <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (dir) begin
              ser_dout <= shadow[0];
              shadow   <= shadow >> 1;
            end else begin
              ser_dout <= shadow[WIDTH-1];
              shadow   <= shadow << 1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          ser_dout <= 1'b0;
          ser_sel  <= SEL_CLR;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_feeder.sv
// Directed self-checking bench for shift_feeder.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_shift_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_dir;
  logic       ser_dout;
  logic [1:0] ser_sel;
  logic       busy;
  logic       word_done;

  int n_chk  = 0;
  int n_pass = 0;

  shift_feeder #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .ser_dout  (ser_dout),
    .ser_sel   (ser_sel),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sel"},   8'(ser_sel),   8'd0);
    chk({tag, ".dout"},  8'(ser_dout),  8'd0);
    chk({tag, ".ready"}, 8'(in_ready),  8'd1);
    chk({tag, ".busy"},  8'(busy),      8'd0);
    chk({tag, ".done"},  8'(word_done), 8'd0);
  endtask

  // seq[3] is the first bit expected on ser_dout
  task automatic run_word(input string tag, input logic [3:0] d,
                          input logic dir, input logic [3:0] seq,
                          input bit noisy);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.sel%0d", tag, i), 8'(ser_sel),
          dir ? 8'd2 : 8'd1);
      chk($sformatf("%s.bit%0d", tag, i), 8'(ser_dout),
          8'(seq[3-i]));
      chk($sformatf("%s.busy%0d", tag, i), 8'(busy), 8'd1);
      chk($sformatf("%s.rdy%0d", tag, i), 8'(in_ready), 8'd0);
      chk($sformatf("%s.wd%0d", tag, i), 8'(word_done), 8'd0);
      if (noisy && i < 3) begin
        in_valid = 1'b1;
        in_data  = 4'($urandom);
        in_dir   = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (i < 3) tick();
    end
    tick();
    chk({tag, ".done"},  8'(word_done), 8'd1);
    chk({tag, ".dsel"},  8'(ser_sel),   8'd0);
    chk({tag, ".dbusy"}, 8'(busy),      8'd0);
    chk({tag, ".drdy"},  8'(in_ready),  8'd1);
    tick();
    chk_idle({tag, ".idle"});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] a_bits;
    logic [3:0] b_bits;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    in_dir   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_idle($sformatf("rst_idle%0d", i));
      tick();
    end

    run_word("l1011", 4'b1011, 1'b0, 4'b1011, 1'b0);
    run_word("r1011", 4'b1011, 1'b1, 4'b1101, 1'b0);

    // back-to-back A then 5, left
    a_bits   = 4'b1010;
    b_bits   = 4'b0101;
    in_valid = 1'b1;
    in_data  = 4'hA;
    in_dir   = 1'b0;
    tick();
    in_data  = 4'h5;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b.a.bit%0d", i), 8'(ser_dout), 8'(a_bits[3-i]));
      chk($sformatf("b2b.a.sel%0d", i), 8'(ser_sel), 8'd1);
      tick();
    end
    chk("b2b.done1", 8'(word_done), 8'd1);
    chk("b2b.rdy1",  8'(in_ready),  8'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b.b.bit%0d", i), 8'(ser_dout), 8'(b_bits[3-i]));
      chk($sformatf("b2b.b.sel%0d", i), 8'(ser_sel), 8'd1);
      chk($sformatf("b2b.b.busy%0d", i), 8'(busy), 8'd1);
      tick();
    end
    chk("b2b.done2", 8'(word_done), 8'd1);
    tick();
    chk_idle("b2b.idle");

    // reset during third shift cycle, with in_valid high
    in_valid = 1'b1;
    in_data  = 4'hF;
    in_dir   = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid.busy", 8'(busy), 8'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk_idle("mid.rst");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mid.nodone%0d", i), 8'(word_done), 8'd0);
      chk($sformatf("mid.nobusy%0d", i), 8'(busy), 8'd0);
      tick();
    end
    run_word("fresh", 4'b1001, 1'b1, 4'b1001, 1'b0);

    // data toggling while busy is ignored
    run_word("noisy", 4'b0110, 1'b0, 4'b0110, 1'b1);
    run_word("noisyr", 4'b0011, 1'b1, 4'b1100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
